// File: rtl/reg_bank_scoreboard_if.sv
// reg_bank_scoreboard_if
// Groups the write-back stream, the decode issue port, the two read ports
// and the status outputs of the register bank into one bundle.
//   master : the surrounding pipeline (write-back selector + decode)
//   slave  : the register bank itself
// Clock and reset are kept outside the bundle as plain ports.
interface reg_bank_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              REG_write_back_flag;
  logic [7:0]        REG_write_back_code;
  logic [DATA_W-1:0] REG_write_back_data;
  logic              ISSUE_valid;
  logic [7:0]        ISSUE_code;
  logic [7:0]        RD_A_code;
  logic [DATA_W-1:0] RD_A_data;
  logic              RD_A_busy;
  logic [7:0]        RD_B_code;
  logic [DATA_W-1:0] RD_B_data;
  logic              RD_B_busy;
  logic              ISSUE_stall;
  logic              WB_illegal;
  logic [15:0]       WB_count;

  modport master (
    output REG_write_back_flag, REG_write_back_code, REG_write_back_data,
    output ISSUE_valid, ISSUE_code, RD_A_code, RD_B_code,
    input  RD_A_data, RD_A_busy, RD_B_data, RD_B_busy,
    input  ISSUE_stall, WB_illegal, WB_count
  );

  modport slave (
    input  REG_write_back_flag, REG_write_back_code, REG_write_back_data,
    input  ISSUE_valid, ISSUE_code, RD_A_code, RD_B_code,
    output RD_A_data, RD_A_busy, RD_B_data, RD_B_busy,
    output ISSUE_stall, WB_illegal, WB_count
  );
endinterface

// File: rtl/reg_bank_scoreboard.sv
// reg_bank_scoreboard
// General-purpose register bank with a write-back scoreboard. Consumes the
// single write-back stream, offers two combinational read ports with
// same-cycle bypass, and keeps one "result pending" bit per register so
// decode can stall on hazards.
// Ports:
//   CLK  - rising-edge clock
//   RST  - asynchronous active-high reset
//   bus  - slave side of reg_bank_scoreboard_if (write-back, issue,
//          read ports A/B, ISSUE_stall, WB_illegal, WB_count)
module reg_bank_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                   CLK,
  input logic                   RST,
  reg_bank_scoreboard_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic              illegal_q, illegal_d;
  logic [15:0]       count_q, count_d;

  logic              wb_commit, wb_bad;
  logic              issue_legal, issue_bad, issue_claim, issue_stall;
  logic              issue_busy;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic              a_busy, b_busy;

  // Codes are compared on all 8 bits; widening to 9 bits lets NUM_REGS=256
  // work without overflow.
  function automatic logic is_legal(input logic [7:0] code);
    return {1'b0, code} < 9'(NUM_REGS);
  endfunction

  function automatic logic is_zero(input logic [7:0] code);
    return ZERO_REG && (code == 8'd0);
  endfunction

  // Classify the write-back and issue requests of this cycle.
  always_comb begin
    wb_commit   = bus.REG_write_back_flag && is_legal(bus.REG_write_back_code)
                  && !is_zero(bus.REG_write_back_code);
    wb_bad      = bus.REG_write_back_flag && !is_legal(bus.REG_write_back_code);
    issue_legal = bus.ISSUE_valid && is_legal(bus.ISSUE_code);
    issue_bad   = bus.ISSUE_valid && !is_legal(bus.ISSUE_code);
  end

  // Storage lookups for the issue code and both read codes.
  always_comb begin
    issue_busy = 1'b0;
    a_reg      = '0;
    a_busy     = 1'b0;
    b_reg      = '0;
    b_busy     = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.ISSUE_code == 8'(i)) issue_busy = busy_q[i];
      if (bus.RD_A_code == 8'(i)) begin
        a_reg  = regs_q[i];
        a_busy = busy_q[i];
      end
      if (bus.RD_B_code == 8'(i)) begin
        b_reg  = regs_q[i];
        b_busy = busy_q[i];
      end
    end
  end

  // A write-back retiring the same code this cycle releases the WAW hazard,
  // so the new claim is accepted rather than stalled.
  always_comb begin
    issue_stall = !RST && issue_legal && issue_busy &&
                  !(wb_commit && (bus.REG_write_back_code == bus.ISSUE_code));
    issue_claim = issue_legal && !is_zero(bus.ISSUE_code) && !issue_stall;
    bus.ISSUE_stall = issue_stall;
  end

  // Read ports: zero/illegal codes read as 0/not-busy, a matching committable
  // write-back is forwarded, everything is forced quiet while in reset.
  always_comb begin
    bus.RD_A_data = '0;
    bus.RD_A_busy = 1'b0;
    bus.RD_B_data = '0;
    bus.RD_B_busy = 1'b0;
    if (!RST && is_legal(bus.RD_A_code) && !is_zero(bus.RD_A_code)) begin
      if (wb_commit && (bus.REG_write_back_code == bus.RD_A_code)) begin
        bus.RD_A_data = bus.REG_write_back_data;
      end else begin
        bus.RD_A_data = a_reg;
        bus.RD_A_busy = a_busy;
      end
    end
    if (!RST && is_legal(bus.RD_B_code) && !is_zero(bus.RD_B_code)) begin
      if (wb_commit && (bus.REG_write_back_code == bus.RD_B_code)) begin
        bus.RD_B_data = bus.REG_write_back_data;
      end else begin
        bus.RD_B_data = b_reg;
        bus.RD_B_busy = b_busy;
      end
    end
  end

  // Next state: the issue claim is applied after the write-back clear so a
  // simultaneous claim on the same register leaves it busy.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    illegal_d = illegal_q || wb_bad || issue_bad;
    count_d   = count_q + 16'(wb_commit);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_commit && (bus.REG_write_back_code == 8'(i))) begin
        regs_d[i] = bus.REG_write_back_data;
        busy_d[i] = 1'b0;
      end
      if (issue_claim && (bus.ISSUE_code == 8'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs_q    <= '{default: '0};
      busy_q    <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign bus.WB_illegal = illegal_q;
  assign bus.WB_count   = count_q;

endmodule

// File: tb/tb_reg_bank_scoreboard.sv
module tb_reg_bank_scoreboard;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  reg_bank_scoreboard_if #(.DATA_W(DATA_W)) bus ();

  reg_bank_scoreboard #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ZERO_REG(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: architectural state as plain arrays.
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  bit                m_busy [NUM_REGS];
  logic [15:0]       m_count;
  bit                m_illegal;

  function automatic bit legal(input logic [7:0] c);
    return int'(c) < NUM_REGS;
  endfunction

  function automatic bit usable(input logic [7:0] c);
    return legal(c) && (c != 8'd0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    m_count   = '0;
    m_illegal = 0;
  endtask

  function automatic bit wb_commits();
    return bus.REG_write_back_flag && usable(bus.REG_write_back_code);
  endfunction

  function automatic bit exp_stall();
    logic [7:0] ic;
    ic = bus.ISSUE_code;
    if (!bus.ISSUE_valid || !legal(ic)) return 0;
    if (!m_busy[ic]) return 0;
    return !(wb_commits() && bus.REG_write_back_code == ic);
  endfunction

  task automatic exp_read(input logic [7:0] c, output logic [DATA_W-1:0] d,
                          output bit b);
    d = '0;
    b = 0;
    if (usable(c)) begin
      if (wb_commits() && bus.REG_write_back_code == c) begin
        d = bus.REG_write_back_data;
      end else begin
        d = m_regs[c];
        b = m_busy[c];
      end
    end
  endtask

  // Apply one cycle's inputs at the falling edge; returns 1ns later so
  // combinational outputs can be sampled.
  task automatic drive(input bit f, input logic [7:0] wc,
                       input logic [DATA_W-1:0] wd, input bit iv,
                       input logic [7:0] ic, input logic [7:0] ac,
                       input logic [7:0] bc);
    @(negedge CLK);
    bus.REG_write_back_flag = f;
    bus.REG_write_back_code = wc;
    bus.REG_write_back_data = wd;
    bus.ISSUE_valid         = iv;
    bus.ISSUE_code          = ic;
    bus.RD_A_code           = ac;
    bus.RD_B_code           = bc;
    #1;
  endtask

  // Advance through the rising edge and update the model from the spec rules.
  task automatic clock_edge();
    bit commit, claim, bad;
    logic [7:0] wc, ic;
    logic [DATA_W-1:0] wd;
    wc     = bus.REG_write_back_code;
    ic     = bus.ISSUE_code;
    wd     = bus.REG_write_back_data;
    commit = wb_commits();
    claim  = bus.ISSUE_valid && usable(ic) && !exp_stall();
    bad    = (bus.REG_write_back_flag && !legal(wc)) ||
             (bus.ISSUE_valid && !legal(ic));
    @(posedge CLK);
    if (commit) begin
      m_regs[wc] = wd;
      m_busy[wc] = 0;
      m_count    = m_count + 16'd1;
    end
    if (claim) m_busy[ic] = 1;
    if (bad) m_illegal = 1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.REG_write_back_flag = 1'b0;
    bus.REG_write_back_code = 8'd0;
    bus.REG_write_back_data = '0;
    bus.ISSUE_valid = 1'b0;
    bus.ISSUE_code  = 8'd0;
    bus.RD_A_code   = 8'd3;
    bus.RD_B_code   = 8'd4;
    model_reset();
    #1;
    checks++;
    if (bus.RD_A_data !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_rd_a_data: got %h expected 0", bus.RD_A_data);
    end
    checks++;
    if (bus.RD_B_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_rd_b_busy: got %b expected 0", bus.RD_B_busy);
    end
    checks++;
    if (bus.WB_count !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_wb_count: got %h expected 0", bus.WB_count);
    end
    checks++;
    if (bus.WB_illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_wb_illegal: got %b expected 0", bus.WB_illegal);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_write_read();
    drive(1, 8'd5, 32'hDEADBEEF, 0, 8'd0, 8'd5, 8'd5);
    checks++;
    if (bus.RD_A_data !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL bypass_a: got %h expected deadbeef", bus.RD_A_data);
    end
    clock_edge();
    drive(0, 8'd5, 32'h0, 0, 8'd0, 8'd5, 8'd5);
    checks++;
    if (bus.RD_A_data !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL stored_a: got %h expected deadbeef", bus.RD_A_data);
    end
    checks++;
    if (bus.WB_count !== 16'd1) begin
      errors++; $display("[TB] FAIL count_after_write: got %0d expected 1", bus.WB_count);
    end
    clock_edge();
  endtask

  task automatic test_scoreboard();
    drive(0, 8'd0, 32'h0, 1, 8'd7, 8'd0, 8'd7);
    clock_edge();
    drive(0, 8'd0, 32'h0, 1, 8'd7, 8'd0, 8'd7);
    checks++;
    if (bus.RD_B_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_after_issue: got %b expected 1", bus.RD_B_busy);
    end
    checks++;
    if (bus.ISSUE_stall !== 1'b1) begin
      errors++; $display("[TB] FAIL waw_stall: got %b expected 1", bus.ISSUE_stall);
    end
    clock_edge();
    drive(1, 8'd7, 32'h12, 0, 8'd0, 8'd0, 8'd7);
    checks++;
    if (bus.RD_B_busy !== 1'b0 || bus.RD_B_data !== 32'h12) begin
      errors++;
      $display("[TB] FAIL wb_bypass_b: got busy %b data %h expected busy 0 data 12",
               bus.RD_B_busy, bus.RD_B_data);
    end
    clock_edge();
    drive(0, 8'd0, 32'h0, 0, 8'd0, 8'd0, 8'd7);
    checks++;
    if (bus.RD_B_busy !== 1'b0 || bus.RD_B_data !== 32'h12) begin
      errors++;
      $display("[TB] FAIL after_wb_b: got busy %b data %h expected busy 0 data 12",
               bus.RD_B_busy, bus.RD_B_data);
    end
    clock_edge();
  endtask

  task automatic test_simultaneous();
    drive(0, 8'd0, 32'h0, 1, 8'd9, 8'd9, 8'd0);
    clock_edge();
    drive(1, 8'd9, 32'hA5, 1, 8'd9, 8'd9, 8'd0);
    checks++;
    if (bus.ISSUE_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_stall: got %b expected 0", bus.ISSUE_stall);
    end
    clock_edge();
    drive(0, 8'd0, 32'h0, 0, 8'd0, 8'd9, 8'd0);
    checks++;
    if (bus.RD_A_data !== 32'hA5 || bus.RD_A_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_result: got data %h busy %b expected data a5 busy 1",
               bus.RD_A_data, bus.RD_A_busy);
    end
    clock_edge();
  endtask

  task automatic test_zero_illegal();
    logic [15:0] count_before;
    count_before = m_count;
    drive(1, 8'd0, 32'hFFFFFFFF, 0, 8'd0, 8'd0, 8'd5);
    checks++;
    if (bus.RD_A_data !== 32'd0) begin
      errors++; $display("[TB] FAIL zero_reg_read: got %h expected 0", bus.RD_A_data);
    end
    clock_edge();
    drive(1, 8'd40, 32'h55555555, 0, 8'd0, 8'd40, 8'd5);
    checks++;
    if (bus.RD_A_data !== 32'd0 || bus.RD_A_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_read: got data %h busy %b expected 0/0",
               bus.RD_A_data, bus.RD_A_busy);
    end
    checks++;
    if (bus.WB_count !== count_before) begin
      errors++; $display("[TB] FAIL zero_not_counted: got %0d expected %0d", bus.WB_count, count_before);
    end
    clock_edge();
    drive(0, 8'd0, 32'h0, 0, 8'd0, 8'd0, 8'd5);
    checks++;
    if (bus.WB_illegal !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_flag: got %b expected 1", bus.WB_illegal);
    end
    checks++;
    if (bus.RD_B_data !== 32'hDEADBEEF || bus.WB_count !== count_before) begin
      errors++;
      $display("[TB] FAIL illegal_no_effect: got reg5 %h count %0d expected deadbeef %0d",
               bus.RD_B_data, bus.WB_count, count_before);
    end
    repeat (3) clock_edge();
    #1;
    checks++;
    if (bus.WB_illegal !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_sticky: got %b expected 1", bus.WB_illegal);
    end
  endtask

  task automatic test_mid_reset();
    drive(1, 8'd5, 32'h01234567, 0, 8'd0, 8'd5, 8'd9);
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (bus.RD_A_data !== 32'd0 || bus.RD_B_busy !== 1'b0 || bus.WB_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got a %h busy_b %b count %0d expected 0/0/0",
               bus.RD_A_data, bus.RD_B_busy, bus.WB_count);
    end
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    bus.REG_write_back_flag = 1'b0;
    RST = 1'b0;
    #1;
    checks++;
    if (bus.RD_A_data !== 32'd0 || bus.WB_illegal !== 1'b0 || bus.WB_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL no_commit_in_reset: got a %h illegal %b count %0d expected 0/0/0",
               bus.RD_A_data, bus.WB_illegal, bus.WB_count);
    end
  endtask

  function automatic logic [7:0] rand_code();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [DATA_W-1:0] ea, eb;
    bit ba, bb;
    for (int n = 0; n < 400; n++) begin
      drive(bit'($urandom_range(0, 1)), rand_code(), $urandom(),
            bit'($urandom_range(0, 1)), rand_code(), rand_code(), rand_code());
      exp_read(bus.RD_A_code, ea, ba);
      exp_read(bus.RD_B_code, eb, bb);
      checks++;
      if (bus.RD_A_data !== ea || bus.RD_A_busy !== ba) begin
        errors++;
        $display("[TB] FAIL rand_port_a[%0d]: got %h/%b expected %h/%b",
                 n, bus.RD_A_data, bus.RD_A_busy, ea, ba);
      end
      checks++;
      if (bus.RD_B_data !== eb || bus.RD_B_busy !== bb) begin
        errors++;
        $display("[TB] FAIL rand_port_b[%0d]: got %h/%b expected %h/%b",
                 n, bus.RD_B_data, bus.RD_B_busy, eb, bb);
      end
      checks++;
      if (bus.ISSUE_stall !== exp_stall()) begin
        errors++;
        $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", n, bus.ISSUE_stall, exp_stall());
      end
      checks++;
      if (bus.WB_count !== m_count || bus.WB_illegal !== m_illegal) begin
        errors++;
        $display("[TB] FAIL rand_status[%0d]: got %0d/%b expected %0d/%b",
                 n, bus.WB_count, bus.WB_illegal, m_count, m_illegal);
      end
      clock_edge();
    end
  endtask

  task automatic test_count_wrap();
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    for (int n = 0; n < 65535; n++) begin
      drive(1, 8'd1, 32'(n), 0, 8'd0, 8'd1, 8'd0);
      clock_edge();
    end
    drive(1, 8'd1, 32'hCAFE0000, 0, 8'd0, 8'd1, 8'd0);
    checks++;
    if (bus.WB_count !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL count_preload: got %h expected ffff", bus.WB_count);
    end
    clock_edge();
    drive(0, 8'd0, 32'h0, 0, 8'd0, 8'd1, 8'd0);
    checks++;
    if (bus.WB_count !== 16'h0000 || bus.WB_count !== m_count) begin
      errors++; $display("[TB] FAIL count_wrap: got %h expected 0000", bus.WB_count);
    end
    checks++;
    if (bus.RD_A_data !== 32'hCAFE0000) begin
      errors++; $display("[TB] FAIL last_write_stored: got %h expected cafe0000", bus.RD_A_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_zero_illegal();
    test_mid_reset();
    test_random();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_scoreboard.md
Name: reg_bank_scoreboard

Overview:
- General-purpose register bank with write-back scoreboard. It sits directly downstream of the write-back selector and consumes its single REG_write_back_flag/code/data stream.
- Provides two combinational read ports for the decode/operand stage, with same-cycle write-back bypass.
- Tracks per-register "result pending" bits so decode can stall on hazards until the owning unit (ALU, STACK, JMP, DMA, SCHED, UART) writes back.

Parameters:
- NUM_REGS, 32, number of architectural registers; legal codes 0..NUM_REGS-1; power of two, 2..256.
- DATA_W, 32, register width.
- ZERO_REG, 1, when 1 register 0 reads as 0, and writes to it and issue claims on it are discarded.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- REG_write_back_flag  input  1  write request from write-back selector.
- REG_write_back_code  input  8  destination register code.
- REG_write_back_data  input  DATA_W  write data.
- ISSUE_valid  input  1  decode claims a destination this cycle.
- ISSUE_code  input  8  claimed destination register code.
- RD_A_code  input  8  read port A register code.
- RD_A_data  output  DATA_W  read port A data.
- RD_A_busy  output  1  read port A register has a pending write.
- RD_B_code  input  8  read port B register code.
- RD_B_data  output  DATA_W  read port B data.
- RD_B_busy  output  1  read port B register has a pending write.
- ISSUE_stall  output  1  ISSUE_code is already busy (WAW); the issue is refused.
- WB_illegal  output  1  registered sticky flag: a write or issue used a code >= NUM_REGS.
- WB_count  output  16  registered count of committed writes; wraps 0xFFFF -> 0.

Behaviour:
- Reset (RST=1, asynchronous):
  - All registers cleared to 0.
  - All busy bits cleared.
  - WB_illegal=0, WB_count=0.
  - Read outputs become 0/not-busy combinationally.
  - A reset mid-operation drops any pending claims; no write is committed in that cycle.
- Write commit: on CLK rising edge with REG_write_back_flag=1 and a legal code (not 0 when ZERO_REG=1):
  - reg[code] <= data.
  - busy[code] <= 0.
  - WB_count increments.
  - Latency: 1 cycle to storage, 0 cycles through bypass.
- Discarded writes:
  - Legal code 0 with ZERO_REG=1: discarded, not counted.
  - Illegal code: discarded, not counted, sets WB_illegal; the flag stays set until reset.
- Flag low: code and data are ignored entirely.
- Issue: on CLK rising edge with ISSUE_valid=1, legal code and ISSUE_stall=0: busy[code] <= 1.
  - Illegal ISSUE_code sets WB_illegal and claims nothing.
- ISSUE_stall = ISSUE_valid & legal & busy[ISSUE_code] & ~(write-back clearing the same code this cycle). It is combinational.
- Simultaneous write-back and issue to the same code in one cycle:
  - Data is written.
  - The busy bit ends at 1: the new claim wins over the clear.
- Reads (combinational, per port):
  - Code 0 with ZERO_REG=1: data=0, busy=0.
  - Illegal code: data=0, busy=0.
  - Bypass: if REG_write_back_flag=1 and the write code equals the read code (legal, committable), data = REG_write_back_data and busy=0.
  - Otherwise data = reg[code] and busy = busy[code].
- Ports A and B are independent and may address the same register.
- Codes are compared on all 8 bits; there is no truncation to log2(NUM_REGS).
- Busy bits hold indefinitely; there is no timeout.

Test Plan:
- Reset then read: assert RST mid-simulation with no clock edge -> RD_A_data=0, RD_B_busy=0, WB_count=0 immediately.
- Write/read:
  - Write code 5 data 0xDEADBEEF -> same cycle RD_A_code=5 gives 0xDEADBEEF (bypass).
  - Next cycle, flag low -> still 0xDEADBEEF; WB_count=1.
- Scoreboard:
  - Issue code 7 -> next cycle RD_B_busy=1 for code 7.
  - Re-issue 7 -> ISSUE_stall=1.
  - Write-back code 7 data 0x12 -> same cycle RD_B_busy=0 and data 0x12; afterwards busy=0.
- Simultaneous: write-back and issue code 9 in the same cycle, data 0xA5 -> next cycle reg9=0xA5, busy[9]=1, ISSUE_stall=0 in that cycle.
- Zero/illegal:
  - Write code 0 data 0xFFFFFFFF -> RD_A_data=0, WB_count unchanged.
  - Write code 40 (NUM_REGS=32) -> WB_illegal=1 after the edge, no register changed, flag remains set until RST.
- Counter wrap: preload by issuing 65535 writes, then one more write -> WB_count=0.
